// File: rtl/fault_pair_seq.sv
// fault_pair_seq: buffers BIST fault reports, then streams every unordered
// entry pair (i<j) as row/block operands to the redundancy address comparator.
//
// Ports:
//   clk, rst, clr       clock, sync active-high reset, sync clear
//   flt_valid/ready     fault report handshake (ready only while collecting)
//   flt_row/col/blk     fault report payload
//   flt_last            last report of the BIST run
//   rrx_*/npry_*        row/block operands of entries i and j
//   pair_valid/i/j      operand valid strobe and pair indices
//   fault_cnt           entries stored
//   overflow            sticky: unique report arrived while buffer full
//   done                pair walk complete (held until rst/clr)
//
// Option: define FAULT_DEDUP_EN to drop reports equal to a stored entry.

module fault_pair_seq #(
  parameter  int ADDR_W = 10,
  parameter  int BLK_W  = 2,
  parameter  int DEPTH  = 8,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              flt_valid,
  output logic              flt_ready,
  input  logic [ADDR_W-1:0] flt_row,
  input  logic [ADDR_W-1:0] flt_col,
  input  logic [BLK_W-1:0]  flt_blk,
  input  logic              flt_last,
  output logic [ADDR_W-1:0] rrx_addr,
  output logic [ADDR_W-1:0] npry_addr,
  output logic [BLK_W-1:0]  rrx_block,
  output logic [BLK_W-1:0]  npry_block,
  output logic              pair_valid,
  output logic [IDX_W-1:0]  pair_i,
  output logic [IDX_W-1:0]  pair_j,
  output logic [CNT_W-1:0]  fault_cnt,
  output logic              overflow,
  output logic              done
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e state_q;

  logic [ADDR_W-1:0] row_q [DEPTH];
  logic [BLK_W-1:0]  blk_q [DEPTH];
`ifdef FAULT_DEDUP_EN
  logic [ADDR_W-1:0] col_q [DEPTH];
`else
  logic unused_col;
  assign unused_col = ^flt_col;
`endif

  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic [ADDR_W-1:0] rrx_q;
  logic [ADDR_W-1:0] npry_q;
  logic [BLK_W-1:0]  rblk_q;
  logic [BLK_W-1:0]  nblk_q;
  logic              pv_q;
  logic [IDX_W-1:0]  pi_q;
  logic [IDX_W-1:0]  pj_q;
  logic              ovf_q;
  logic              done_q;

  logic              acc;
  logic              full;
  logic              dup;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [CNT_W-1:0]  cnt_d;
  logic              j_last;
  logic              i_last;
  logic [IDX_W-1:0]  ni;
  logic [IDX_W-1:0]  nj;
  logic [ADDR_W-1:0] ra_row;
  logic [ADDR_W-1:0] rb_row;
  logic [BLK_W-1:0]  ra_blk;
  logic [BLK_W-1:0]  rb_blk;

  always_comb begin
    acc    = flt_valid & ready_q & (state_q == COLLECT);
    full   = (cnt_q == CNT_W'(DEPTH));
    dup    = 1'b0;
`ifdef FAULT_DEDUP_EN
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < cnt_q) &&
          (row_q[k] == flt_row) &&
          (col_q[k] == flt_col) &&
          (blk_q[k] == flt_blk)) begin
        dup = 1'b1;
      end
    end
`endif
    wr_en  = acc & ~dup & ~full;
    wr_idx = cnt_q[IDX_W-1:0];
    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, wr_en};

    j_last = ({1'b0, pj_q} == (cnt_q - CNT_W'(1)));
    i_last = ({1'b0, pi_q} == (cnt_q - CNT_W'(2)));

    // Outside SCAN the next pair is always the first one (0,1).
    ni = '0;
    nj = IDX_W'(1);
    if (state_q == SCAN) begin
      if (!j_last) begin
        ni = pi_q;
        nj = pj_q + IDX_W'(1);
      end else begin
        ni = pi_q + IDX_W'(1);
        nj = pi_q + IDX_W'(2);
      end
    end

    // Forward the report being written so the first pair can include
    // the final (flt_last) entry on the very first SCAN cycle.
    ra_row = row_q[ni];
    ra_blk = blk_q[ni];
    rb_row = row_q[nj];
    rb_blk = blk_q[nj];
    if (wr_en && (wr_idx == ni)) begin
      ra_row = flt_row;
      ra_blk = flt_blk;
    end
    if (wr_en && (wr_idx == nj)) begin
      rb_row = flt_row;
      rb_blk = flt_blk;
    end
  end

  // Entry storage is only invalidated by rst/clr, never cleared.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_en) begin
      row_q[wr_idx] <= flt_row;
      blk_q[wr_idx] <= flt_blk;
`ifdef FAULT_DEDUP_EN
      col_q[wr_idx] <= flt_col;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      rrx_q   <= '0;
      npry_q  <= '0;
      rblk_q  <= '0;
      nblk_q  <= '0;
      pv_q    <= 1'b0;
      pi_q    <= '0;
      pj_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          cnt_q <= cnt_d;
          if (acc && !dup && full) begin
            ovf_q <= 1'b1;
          end
          if (acc && flt_last) begin
            ready_q <= 1'b0;
            if (cnt_d >= CNT_W'(2)) begin
              state_q <= SCAN;
              pv_q    <= 1'b1;
              pi_q    <= ni;
              pj_q    <= nj;
              rrx_q   <= ra_row;
              npry_q  <= rb_row;
              rblk_q  <= ra_blk;
              nblk_q  <= rb_blk;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (j_last && i_last) begin
            state_q <= DONE;
            pv_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pi_q   <= ni;
            pj_q   <= nj;
            rrx_q  <= ra_row;
            npry_q <= rb_row;
            rblk_q <= ra_blk;
            nblk_q <= rb_blk;
          end
        end
        DONE: begin
          pv_q   <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign flt_ready  = ready_q;
  assign rrx_addr   = rrx_q;
  assign npry_addr  = npry_q;
  assign rrx_block  = rblk_q;
  assign npry_block = nblk_q;
  assign pair_valid = pv_q;
  assign pair_i     = pi_q;
  assign pair_j     = pj_q;
  assign fault_cnt  = cnt_q;
  assign overflow   = ovf_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fault_pair_seq.sv
// tb_fault_pair_seq: directed bench for fault_pair_seq.
// Inputs change 1ns after the rising edge; outputs are checked there too.

module tb_fault_pair_seq;

  localparam int ADDR_W = 10;
  localparam int BLK_W  = 2;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              flt_valid;
  logic              flt_ready;
  logic [ADDR_W-1:0] flt_row;
  logic [ADDR_W-1:0] flt_col;
  logic [BLK_W-1:0]  flt_blk;
  logic              flt_last;
  logic [ADDR_W-1:0] rrx_addr;
  logic [ADDR_W-1:0] npry_addr;
  logic [BLK_W-1:0]  rrx_block;
  logic [BLK_W-1:0]  npry_block;
  logic              pair_valid;
  logic [IDX_W-1:0]  pair_i;
  logic [IDX_W-1:0]  pair_j;
  logic [CNT_W-1:0]  fault_cnt;
  logic              overflow;
  logic              done;

  int checks = 0;
  int errors = 0;

  fault_pair_seq #(
    .ADDR_W (ADDR_W),
    .BLK_W  (BLK_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .flt_valid  (flt_valid),
    .flt_ready  (flt_ready),
    .flt_row    (flt_row),
    .flt_col    (flt_col),
    .flt_blk    (flt_blk),
    .flt_last   (flt_last),
    .rrx_addr   (rrx_addr),
    .npry_addr  (npry_addr),
    .rrx_block  (rrx_block),
    .npry_block (npry_block),
    .pair_valid (pair_valid),
    .pair_i     (pair_i),
    .pair_j     (pair_j),
    .fault_cnt  (fault_cnt),
    .overflow   (overflow),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int row, input int col,
                      input int blk, input bit last);
    flt_valid = 1'b1;
    flt_row   = ADDR_W'(row);
    flt_col   = ADDR_W'(col);
    flt_blk   = BLK_W'(blk);
    flt_last  = last;
    tick();
    flt_valid = 1'b0;
    flt_last  = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int mi, mj, npairs;
    rst = 1'b1;
    clr = 1'b0;
    flt_valid = 1'b0;
    flt_row = '0;
    flt_col = '0;
    flt_blk = '0;
    flt_last = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cnt", fault_cnt, 0);
    chk("rst_ready", flt_ready, 1);
    chk("rst_pv", pair_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rrx", rrx_addr, 0);
    chk("rst_npry", npry_addr, 0);

    // Three reports -> pairs (0,1),(0,2),(1,2)
    send(5, 0, 0, 1'b0);
    send(5, 1, 1, 1'b0);
    send(9, 2, 0, 1'b1);
    chk("t1_cnt", fault_cnt, 3);
    chk("t1_ready", flt_ready, 0);
    chk("t1_p0_pv", pair_valid, 1);
    chk("t1_p0_i", pair_i, 0);
    chk("t1_p0_j", pair_j, 1);
    chk("t1_p0_rrx", rrx_addr, 5);
    chk("t1_p0_npry", npry_addr, 5);
    chk("t1_p0_rb", rrx_block, 0);
    chk("t1_p0_nb", npry_block, 1);
    tick();
    chk("t1_p1_pv", pair_valid, 1);
    chk("t1_p1_i", pair_i, 0);
    chk("t1_p1_j", pair_j, 2);
    chk("t1_p1_rrx", rrx_addr, 5);
    chk("t1_p1_npry", npry_addr, 9);
    chk("t1_p1_nb", npry_block, 0);
    tick();
    chk("t1_p2_pv", pair_valid, 1);
    chk("t1_p2_i", pair_i, 1);
    chk("t1_p2_j", pair_j, 2);
    chk("t1_p2_rrx", rrx_addr, 5);
    chk("t1_p2_npry", npry_addr, 9);
    chk("t1_p2_rb", rrx_block, 1);
    tick();
    chk("t1_end_pv", pair_valid, 0);
    chk("t1_end_done", done, 1);
    // Reports in DONE are ignored
    send(7, 7, 3, 1'b1);
    chk("t1_ign_cnt", fault_cnt, 3);
    chk("t1_ign_done", done, 1);
    chk("t1_ign_ovf", overflow, 0);

    // Nine unique reports into an 8-deep buffer
    do_clr();
    chk("t2_clr_cnt", fault_cnt, 0);
    chk("t2_clr_done", done, 0);
    for (int k = 0; k < 9; k++) begin
      send(k, k + 100, k % 4, k == 8);
    end
    chk("t2_cnt", fault_cnt, 8);
    chk("t2_ovf", overflow, 1);
    mi = 0;
    mj = 1;
    npairs = 0;
    for (int c = 0; c < 40; c++) begin
      if (!pair_valid) break;
      chk("t2_i", pair_i, mi);
      chk("t2_j", pair_j, mj);
      chk("t2_rrx", rrx_addr, mi);
      chk("t2_npry", npry_addr, mj);
      chk("t2_rb", rrx_block, mi % 4);
      chk("t2_nb", npry_block, mj % 4);
      npairs++;
      if (mj < 7) begin
        mj++;
      end else begin
        mi++;
        mj = mi + 1;
      end
      tick();
    end
    chk("t2_npairs", npairs, 28);
    chk("t2_done", done, 1);
    chk("t2_ovf_hold", overflow, 1);

    // Single report with flt_last
    do_clr();
    chk("t3_clr_ovf", overflow, 0);
    send(4, 4, 3, 1'b1);
    chk("t3_cnt", fault_cnt, 1);
    chk("t3_pv", pair_valid, 0);
    chk("t3_done", done, 1);

    // Identical report sent twice
    do_clr();
    send(3, 7, 2, 1'b0);
    send(3, 7, 2, 1'b1);
`ifdef FAULT_DEDUP_EN
    chk("t4_cnt", fault_cnt, 1);
    chk("t4_pv", pair_valid, 0);
    chk("t4_done", done, 1);
`else
    chk("t4_cnt", fault_cnt, 2);
    chk("t4_pv", pair_valid, 1);
    chk("t4_i", pair_i, 0);
    chk("t4_j", pair_j, 1);
    chk("t4_rrx", rrx_addr, 3);
    chk("t4_npry", npry_addr, 3);
    tick();
    chk("t4_done", done, 1);
`endif
    chk("t4_ovf", overflow, 0);

    // clr on the 2nd SCAN cycle of a 4-entry walk
    do_clr();
    send(10, 0, 0, 1'b0);
    send(11, 0, 1, 1'b0);
    send(12, 0, 2, 1'b0);
    send(13, 0, 3, 1'b1);
    chk("t5_p0_j", pair_j, 1);
    tick();
    chk("t5_p1_pv", pair_valid, 1);
    chk("t5_p1_j", pair_j, 2);
    clr = 1'b1;
    flt_valid = 1'b1;
    flt_row = 10'd99;
    tick();
    clr = 1'b0;
    flt_valid = 1'b0;
    chk("t5_clr_pv", pair_valid, 0);
    chk("t5_clr_cnt", fault_cnt, 0);
    chk("t5_clr_ready", flt_ready, 1);
    chk("t5_clr_done", done, 0);
    send(20, 1, 1, 1'b0);
    send(21, 2, 2, 1'b1);
    chk("t5_new_pv", pair_valid, 1);
    chk("t5_new_i", pair_i, 0);
    chk("t5_new_j", pair_j, 1);
    chk("t5_new_rrx", rrx_addr, 20);
    chk("t5_new_npry", npry_addr, 21);
    chk("t5_new_rb", rrx_block, 1);
    chk("t5_new_nb", npry_block, 2);
    tick();
    chk("t5_end_pv", pair_valid, 0);
    chk("t5_end_done", done, 1);

    // rst behaves like clr
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_cnt", fault_cnt, 0);
    chk("t6_done", done, 0);
    chk("t6_ready", flt_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
